// File: rtl/keypad_scan_cntr_pkg.sv
// Shared definitions for the 4x4 keypad scanner and its consumers (mode/timer logic).
// Holds the FSM encoding, parameter defaults and the key-code mapping.
package keypad_scan_cntr_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  localparam int DEF_SCAN_DIV       = 100000;
  localparam int DEF_DEBOUNCE_SCANS = 10;

  localparam int          KEY_ROWS   = 4;
  localparam int          KEY_COLS   = 4;
  localparam int          KEY_CODE_W = 4;
  localparam logic [3:0]  COL_FIRST  = 4'b0001;

  // Key code is row_idx*4 + col_idx, i.e. row index in the upper two bits.
  function automatic logic [KEY_CODE_W-1:0] key_code(input logic [1:0] row_idx,
                                                     input logic [1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/keypad_scan_cntr_scan_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, counter wraps DIV-1 -> 0.
// Shared by the keypad column scan and the FND digit strobe.
module scan_tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan_cntr.sv
// 4x4 matrix keypad scanner: strobes columns, reads rows back, debounces press and
// release, and reports a key code with a level-valid flag and press/release pulses.
module keypad_scan_cntr
  import keypad_scan_cntr_pkg::*;
#(
  parameter int SCAN_DIV       = DEF_SCAN_DIV,
  parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_pe,
  output logic       key_ne,
  output state_e     dbg_state
);

  localparam int            CW     = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_SCANS);

  logic       tick;
  logic [3:0] row_meta_q, row_s_q;

  state_e          state_q;
  logic [3:0]      col_q, pat_q, key_value_q;
  logic            key_valid_q, key_pe_q, key_ne_q;
  logic [CW-1:0]   cnt_q, rcnt_q;
  logic [CW-1:0]   cnt_inc_d, rcnt_inc_d;
  logic [3:0]      col_rot_d;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick_o (tick)
  );

  // row is asynchronous to clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_meta_q <= 4'd0;
      row_s_q    <= 4'd0;
    end else begin
      row_meta_q <= row;
      row_s_q    <= row_meta_q;
    end
  end

  // Saturating increments so a long press never wraps the counters.
  always_comb begin
    cnt_inc_d  = (cnt_q  == DB_MAX) ? cnt_q  : cnt_q  + 1'b1;
    rcnt_inc_d = (rcnt_q == DB_MAX) ? rcnt_q : rcnt_q + 1'b1;
    col_rot_d  = {col_q[2:0], col_q[3]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SCAN;
      col_q       <= COL_FIRST;
      pat_q       <= 4'd0;
      key_value_q <= 4'd0;
      key_valid_q <= 1'b0;
      key_pe_q    <= 1'b0;
      key_ne_q    <= 1'b0;
      cnt_q       <= '0;
      rcnt_q      <= '0;
    end else begin
      key_pe_q <= 1'b0;
      key_ne_q <= 1'b0;
      if (tick) begin
        case (state_q)
          ST_SCAN: begin
            if (is_onehot(row_s_q)) begin
              pat_q   <= row_s_q;
              cnt_q   <= CW'(1);
              state_q <= ST_DEBOUNCE;
            end else begin
              col_q <= col_rot_d;
            end
          end
          ST_DEBOUNCE: begin
            if (row_s_q == pat_q) begin
              cnt_q <= cnt_inc_d;
              if (cnt_inc_d == DB_MAX) begin
                key_value_q <= key_code(onehot_idx(pat_q), onehot_idx(col_q));
                key_valid_q <= 1'b1;
                key_pe_q    <= 1'b1;
                rcnt_q      <= '0;
                state_q     <= ST_HELD;
              end
            end else begin
              state_q <= ST_SCAN;
              col_q   <= col_rot_d;
            end
          end
          ST_HELD: begin
            // Only the held row matters; extra keys on other rows are ignored.
            if ((row_s_q & pat_q) == 4'd0) begin
              if (rcnt_inc_d == DB_MAX) begin
                key_valid_q <= 1'b0;
                key_ne_q    <= 1'b1;
                rcnt_q      <= '0;
                state_q     <= ST_SCAN;
                col_q       <= col_rot_d;
              end else begin
                rcnt_q <= rcnt_inc_d;
              end
            end else begin
              rcnt_q <= '0;
            end
          end
          default: state_q <= ST_SCAN;
        endcase
      end
    end
  end

  assign col       = col_q;
  assign key_value = key_value_q;
  assign key_valid = key_valid_q;
  assign key_pe    = key_pe_q;
  assign key_ne    = key_ne_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scan_cntr.sv
// Bench for keypad_scan_cntr: a physical keypad model (set of pressed keys) drives the
// rows, and a tick-level reference model of the scan/debounce rules predicts outputs.
module tb_keypad_scan_cntr;
  import keypad_scan_cntr_pkg::*;

  localparam int DIV = 8;
  localparam int DB  = 3;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] row = 4'd0;
  logic [3:0] col, key_value;
  logic       key_valid, key_pe, key_ne;
  state_e     dbg_state;

  keypad_scan_cntr #(.SCAN_DIV(DIV), .DEBOUNCE_SCANS(DB)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .row      (row),
    .col      (col),
    .key_value(key_value),
    .key_valid(key_valid),
    .key_pe   (key_pe),
    .key_ne   (key_ne),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  // reference model state (tick granularity)
  int         m_col;
  bit         m_held;
  logic [3:0] m_pat;
  int         m_seen;
  int         m_quiet;
  bit         e_valid, e_pe, e_ne;
  logic [3:0] e_value;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int bit_index(input logic [3:0] v);
    int idx = 0;
    for (int i = 0; i < 4; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  // Rows seen on the driven column given the set of physically pressed keys.
  function automatic logic [3:0] rows_for(input logic [15:0] keys, input int c);
    logic [3:0] v;
    for (int r = 0; r < 4; r++) v[r] = keys[r*4 + c];
    return v;
  endfunction

  task automatic model_reset();
    m_col = 0; m_held = 0; m_pat = 4'd0; m_seen = 0; m_quiet = 0;
    e_valid = 0; e_pe = 0; e_ne = 0; e_value = 4'd0;
  endtask

  task automatic model_tick(input logic [3:0] r);
    e_pe = 0;
    e_ne = 0;
    if (m_held) begin
      m_quiet = ((r & m_pat) == 4'd0) ? m_quiet + 1 : 0;
      if (m_quiet == DB) begin
        m_held = 0; m_quiet = 0; e_valid = 0; e_ne = 1;
        m_col = (m_col + 1) % 4;
      end
    end else if (m_seen > 0) begin
      if (r == m_pat) begin
        m_seen++;
        if (m_seen == DB) begin
          m_held = 1; m_seen = 0; m_quiet = 0;
          e_valid = 1; e_pe = 1;
          e_value = 4'(bit_index(r) * 4 + m_col);
          exp_q.push_back(e_value);
        end
      end else begin
        m_seen = 0;
        m_col = (m_col + 1) % 4;
      end
    end else if ($countones(r) == 1) begin
      m_pat = r;
      m_seen = 1;
    end else begin
      m_col = (m_col + 1) % 4;
    end
  endtask

  // driver: one full tick period with the given keys held
  task automatic do_tick(input logic [15:0] keys);
    logic [3:0] r;
    @(negedge clk);
    r = rows_for(keys, m_col);
    row = r;
    for (int i = 1; i <= DIV; i++) begin
      @(posedge clk);
      #1;
      if (i < DIV) begin
        check_eq("pe_between_ticks", key_pe, 1'b0);
        check_eq("ne_between_ticks", key_ne, 1'b0);
        check_eq("col_between_ticks", col, 16'(1 << m_col));
      end
    end
    model_tick(r);
    check_eq("col", col, 16'(1 << m_col));
    check_eq("key_valid", key_valid, e_valid);
    check_eq("key_value", key_value, e_value);
    check_eq("key_pe", key_pe, e_pe);
    check_eq("key_ne", key_ne, e_ne);
    if (key_pe) begin
      if (exp_q.size() == 0) check_eq("pe_unexpected", key_pe, 1'b0);
      else check_eq("pe_code", key_value, exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    row = 4'd0;
    #1;
    model_reset();
    exp_q.delete();
    check_eq("rst_col", col, 16'(COL_FIRST));
    check_eq("rst_valid", key_valid, 1'b0);
    check_eq("rst_value", key_value, 4'd0);
    check_eq("rst_pe", key_pe, 1'b0);
    check_eq("rst_ne", key_ne, 1'b0);
    check_eq("rst_state", dbg_state, ST_SCAN);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic idle_to_col(input int c);
    for (int i = 0; i < 4 && m_col != c; i++) do_tick(16'd0);
  endtask

  task automatic hold(input logic [15:0] keys, input int n);
    for (int i = 0; i < n; i++) do_tick(keys);
  endtask

  initial begin
    logic [15:0] keys;
    int choice;
    model_reset();
    do_reset();
    do_tick(16'd0);                      // first tick after reset: col 0001 -> 0010

    // clean press of key 10 (row 2, col 2) and release
    idle_to_col(2);
    hold(16'(1 << 10), 5);
    check_eq("clean_valid", key_valid, 1'b1);
    check_eq("clean_code", key_value, 4'd10);
    hold(16'd0, 4);

    // press bounce then stable press of key 5
    idle_to_col(1);
    for (int i = 0; i < 3; i++) begin
      do_tick(16'(1 << 5));
      do_tick(16'd0);
    end
    hold(16'(1 << 5), 8);
    check_eq("bounce_then_held", key_valid, 1'b1);

    // release bounce: drop two ticks, return, then real release
    hold(16'd0, 2);
    hold(16'(1 << 5), 2);
    check_eq("rel_bounce_valid", key_valid, 1'b1);
    hold(16'd0, 4);

    // multi-key: keys 0 and 4 share column 0
    idle_to_col(0);
    hold(16'h0011, 6);
    hold(16'd0, 2);
    hold(16'h0001, 8);                   // key 0 alone gets accepted
    hold(16'h0011, 3);                   // second key while held: ignored
    check_eq("multi_held", key_valid, 1'b1);
    hold(16'h0010, 3);                   // release key 0 with key 4 still down
    check_eq("multi_code", key_value, 4'd0);
    hold(16'd0, 4);

    // reset while HELD
    hold(16'(1 << 10), 8);
    check_eq("pre_reset_valid", key_valid, 1'b1);
    do_reset();
    hold(16'd0, 4);

    // randomized keypad activity
    for (int n = 0; n < 30; n++) begin
      choice = $urandom_range(0, 3);
      case (choice)
        0:       keys = 16'd0;
        1, 2:    keys = 16'(1 << $urandom_range(0, 15));
        default: keys = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
      endcase
      hold(keys, $urandom_range(1, 8));
      if ($urandom_range(0, 19) == 0) do_reset();
    end
    hold(16'd0, 4);

    check_eq("pending_pe", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
